// File: rtl/tt_um_jleugeri_ttt_accumulator.sv
// Token accumulator with threshold-based fire scan.
//
// Each processor owns a saturating good/bad token counter pair and a good/bad threshold pair.
// In IDLE, signed token deltas are accepted one per cycle and added to the target's counters
// with clamping to [0, 2^TOKEN_BITS-1]. A scan pass walks all processors in index order. A
// processor fires when good >= good_thr and bad < bad_thr. A firing processor is offered on
// fire_valid/fire_id until the consumer accepts it, and its counters then clear.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready            token-delta handshake (ready only in IDLE)
//   in_target_id                 processor receiving the delta
//   in_new_good/bad_tokens       signed deltas
//   scan_start                   start a scan pass (IDLE only)
//   prog_we/sel/processor_id/value  threshold write port (any state)
//   fire_valid/fire_ready/fire_id   firing-processor handshake
//   scan_done                    one-cycle pulse after the pass completes
module tt_um_jleugeri_ttt_accumulator #(
  parameter int NUM_PROCESSORS = 4,
  parameter int NEW_TOKEN_BITS = 4,
  parameter int TOKEN_BITS     = 8,
  localparam int IW            = $clog2(NUM_PROCESSORS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IW-1:0]             in_target_id,
  input  logic [NEW_TOKEN_BITS-1:0] in_new_good_tokens,
  input  logic [NEW_TOKEN_BITS-1:0] in_new_bad_tokens,
  input  logic                      scan_start,
  input  logic                      prog_we,
  input  logic                      prog_sel,
  input  logic [IW-1:0]             prog_processor_id,
  input  logic [TOKEN_BITS-1:0]     prog_value,
  output logic                      fire_valid,
  input  logic                      fire_ready,
  output logic [IW-1:0]             fire_id,
  output logic                      scan_done
);

  // Two guard bits: one for the sign, one for overflow above the counter range.
  localparam int SW = TOKEN_BITS + 2;
  localparam logic signed [SW-1:0] MaxSum = SW'((64'd1 << TOKEN_BITS) - 64'd1);
  localparam logic [IW-1:0] LastIdx = IW'(NUM_PROCESSORS - 1);
  localparam logic [TOKEN_BITS-1:0] ThrReset = TOKEN_BITS'(1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  scan_done_q, scan_done_d;
  logic [TOKEN_BITS-1:0] good_q     [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0] good_d     [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0] bad_q      [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0] bad_d      [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0] good_thr_q [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0] good_thr_d [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0] bad_thr_q  [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0] bad_thr_d  [NUM_PROCESSORS];
  logic                  fire_now;

  function automatic logic [TOKEN_BITS-1:0] sat_add(input logic [TOKEN_BITS-1:0]     cnt,
                                                    input logic [NEW_TOKEN_BITS-1:0] delta);
    logic signed [SW-1:0] sum;
    sum = $signed({2'b00, cnt}) + SW'($signed(delta));
    if (sum < 0) begin
      return '0;
    end else if (sum > MaxSum) begin
      return '1;
    end
    return sum[TOKEN_BITS-1:0];
  endfunction

  // Evaluated on registered values only, so the offered fire_id is stable while stalled.
  assign fire_now = (state_q == StScan) &&
                    (good_q[idx_q] >= good_thr_q[idx_q]) &&
                    (bad_q[idx_q] < bad_thr_q[idx_q]);

  assign in_ready   = (state_q == StIdle);
  assign fire_valid = fire_now;
  assign fire_id    = fire_now ? idx_q : '0;
  assign scan_done  = scan_done_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    scan_done_d = 1'b0;
    good_d      = good_q;
    bad_d       = bad_q;
    good_thr_d  = good_thr_q;
    bad_thr_d   = bad_thr_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          good_d[in_target_id] = sat_add(good_q[in_target_id], in_new_good_tokens);
          bad_d[in_target_id]  = sat_add(bad_q[in_target_id], in_new_bad_tokens);
        end
        if (scan_start) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        // A firing index only advances on the fire handshake.
        if (!fire_now || fire_ready) begin
          if (fire_now) begin
            good_d[idx_q] = '0;
            bad_d[idx_q]  = '0;
          end
          if (idx_q == LastIdx) begin
            state_d     = StIdle;
            idx_d       = '0;
            scan_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase

    if (prog_we) begin
      if (prog_sel) begin
        bad_thr_d[prog_processor_id] = prog_value;
      end else begin
        good_thr_d[prog_processor_id] = prog_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      scan_done_q <= 1'b0;
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        good_q[i]     <= '0;
        bad_q[i]      <= '0;
        good_thr_q[i] <= ThrReset;
        bad_thr_q[i]  <= ThrReset;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      scan_done_q <= scan_done_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      good_thr_q  <= good_thr_d;
      bad_thr_q   <= bad_thr_d;
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_accumulator.sv
module tb_tt_um_jleugeri_ttt_accumulator;

  localparam int NP  = 4;
  localparam int NTB = 4;
  localparam int TB  = 8;
  localparam int IW  = 2;
  localparam int MAXC = (1 << TB) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  in_target_id;
  logic [NTB-1:0] in_new_good_tokens;
  logic [NTB-1:0] in_new_bad_tokens;
  logic           scan_start;
  logic           prog_we;
  logic           prog_sel;
  logic [IW-1:0]  prog_processor_id;
  logic [TB-1:0]  prog_value;
  logic           fire_valid;
  logic           fire_ready;
  logic [IW-1:0]  fire_id;
  logic           scan_done;

  tt_um_jleugeri_ttt_accumulator #(
    .NUM_PROCESSORS(NP),
    .NEW_TOKEN_BITS(NTB),
    .TOKEN_BITS    (TB)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_target_id      (in_target_id),
    .in_new_good_tokens(in_new_good_tokens),
    .in_new_bad_tokens (in_new_bad_tokens),
    .scan_start        (scan_start),
    .prog_we           (prog_we),
    .prog_sel          (prog_sel),
    .prog_processor_id (prog_processor_id),
    .prog_value        (prog_value),
    .fire_valid        (fire_valid),
    .fire_ready        (fire_ready),
    .fire_id           (fire_id),
    .scan_done         (scan_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integer counters and thresholds per processor.
  int m_good [NP];
  int m_bad  [NP];
  int m_gthr [NP];
  int m_bthr [NP];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > MAXC) return MAXC;
    return v;
  endfunction

  function automatic bool_fires(input int i);
    return (m_good[i] >= m_gthr[i]) && (m_bad[i] < m_bthr[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_good[i] = 0;
      m_bad[i]  = 0;
      m_gthr[i] = 1;
      m_bthr[i] = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < NP; i++) begin
      check({tag, "_good"}, int'(dut.good_q[i]), m_good[i]);
      check({tag, "_bad"}, int'(dut.bad_q[i]), m_bad[i]);
      check({tag, "_gthr"}, int'(dut.good_thr_q[i]), m_gthr[i]);
      check({tag, "_bthr"}, int'(dut.bad_thr_q[i]), m_bthr[i]);
    end
  endtask

  task automatic deliver(input int t, input int g, input int b);
    check("dlv_in_ready", int'(in_ready), 1);
    check("dlv_fire_valid", int'(fire_valid), 0);
    in_valid           = 1'b1;
    in_target_id       = IW'(t);
    in_new_good_tokens = NTB'(g);
    in_new_bad_tokens  = NTB'(b);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    m_good[t] = clamp(m_good[t] + g);
    m_bad[t]  = clamp(m_bad[t] + b);
  endtask

  task automatic prog(input int sel, input int id, input int val);
    prog_we           = 1'b1;
    prog_sel          = sel[0];
    prog_processor_id = IW'(id);
    prog_value        = TB'(val);
    @(posedge clk); #1;
    prog_we = 1'b0;
    if (sel != 0) m_bthr[id] = val;
    else m_gthr[id] = val;
  endtask

  // One full scan pass; every fire is stalled stall_fixed + rand(0..stall_rand) cycles.
  task automatic run_scan(input int stall_fixed, input int stall_rand, input bit with_delta,
                          input int t, input int g, input int b);
    int  exp_ids[$];
    int  k, cyc, stalls, left, fired;
    bit  done, pending;
    check("scan_pre_ready", int'(in_ready), 1);
    if (with_delta) begin
      in_valid           = 1'b1;
      in_target_id       = IW'(t);
      in_new_good_tokens = NTB'(g);
      in_new_bad_tokens  = NTB'(b);
    end
    scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    in_valid   = 1'b0;
    if (with_delta) begin
      m_good[t] = clamp(m_good[t] + g);
      m_bad[t]  = clamp(m_bad[t] + b);
    end
    exp_ids = {};
    for (int i = 0; i < NP; i++) if (bool_fires(i)) exp_ids.push_back(i);
    k = 0; cyc = 0; stalls = 0; done = 1'b0; fired = 0;
    left = stall_fixed + int'($urandom_range(0, stall_rand));
    for (int budget = 0; budget < 400 && !done; budget++) begin
      pending = 1'b0;
      if (scan_done) begin
        done = 1'b1;
      end else begin
        cyc++;
        check("scan_in_ready", int'(in_ready), 0);
        if (fire_valid) begin
          check("fire_id", int'(fire_id), (k < exp_ids.size()) ? exp_ids[k] : -1);
          fired = int'(fire_id);
          if (left > 0) begin
            fire_ready = 1'b0;
            left--;
            stalls++;
          end else begin
            fire_ready = 1'b1;
            pending    = 1'b1;
          end
        end else begin
          check("nofire_id", int'(fire_id), 0);
          fire_ready = 1'($urandom_range(0, 1));
        end
        // scan_start during SCAN must be ignored.
        scan_start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (pending) begin
          m_good[fired] = 0;
          m_bad[fired]  = 0;
          k++;
          left = stall_fixed + int'($urandom_range(0, stall_rand));
        end
      end
    end
    scan_start = 1'b0;
    fire_ready = 1'b0;
    check("scan_done_seen", int'(done), 1);
    check("fire_count", k, exp_ids.size());
    check("scan_cycles", cyc, NP + stalls);
    if (!done) begin
      do_reset();
    end else begin
      check("done_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      check("done_pulse", int'(scan_done), 0);
      check("post_fire_valid", int'(fire_valid), 0);
    end
  endtask

  initial begin
    int seen;
    reset = 1'b1; in_valid = 1'b0; in_target_id = '0; in_new_good_tokens = '0;
    in_new_bad_tokens = '0; scan_start = 1'b0; prog_we = 1'b0; prog_sel = 1'b0;
    prog_processor_id = '0; prog_value = '0; fire_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_fire_valid", int'(fire_valid), 0);
    check("rst_fire_id", int'(fire_id), 0);
    check("rst_scan_done", int'(scan_done), 0);
    check_state("rst");

    // Back-to-back accumulation, single fire on processor 2.
    deliver(2, 3, 0);
    deliver(2, 4, 0);
    deliver(2, -2, 0);
    check("acc_good2", int'(dut.good_q[2]), 5);
    run_scan(0, 0, 1'b0, 0, 0, 0);
    check("clr_good2", int'(dut.good_q[2]), 0);
    check("clr_bad2", int'(dut.bad_q[2]), 0);

    // Good threshold boundary.
    do_reset();
    prog(0, 1, 6);
    deliver(1, 5, 0);
    run_scan(0, 0, 1'b0, 0, 0, 0);
    deliver(1, 1, 0);
    check("thr_good1", int'(dut.good_q[1]), 6);
    run_scan(0, 0, 1'b0, 0, 0, 0);

    // Bad threshold boundary.
    do_reset();
    prog(1, 0, 2);
    deliver(0, 3, 2);
    run_scan(0, 0, 1'b0, 0, 0, 0);
    deliver(0, 0, -1);
    run_scan(0, 0, 1'b0, 0, 0, 0);
    check_state("badthr");

    // Saturation at both ends.
    do_reset();
    for (int n = 0; n < 40; n++) deliver(3, 7, 0);
    check("sat_hi", int'(dut.good_q[3]), 255);
    deliver(1, 3, 3);
    deliver(1, -8, -8);
    check("sat_lo_good", int'(dut.good_q[1]), 0);
    check("sat_lo_bad", int'(dut.bad_q[1]), 0);

    // Stalled fires on 0 and 3.
    do_reset();
    deliver(0, 1, 0);
    deliver(3, 1, 0);
    run_scan(5, 0, 1'b0, 0, 0, 0);
    check_state("stall");

    // Delta coinciding with scan_start is accumulated before the scan.
    do_reset();
    run_scan(0, 0, 1'b1, 1, 2, 0);
    check_state("coinc");

    // Reset while a fire is pending.
    do_reset();
    deliver(2, 1, 0);
    prog(0, 3, 9);
    scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    seen = 0;
    for (int n = 0; n < 10 && !fire_valid; n++) begin
      @(posedge clk); #1;
    end
    check("mid_fire_seen", int'(fire_valid), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check("mid_rst_fire_valid", int'(fire_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_scan_done", int'(scan_done), 0);
    check_state("mid_rst");
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_done2", int'(scan_done), 0);
    check("mid_rst_ready2", int'(in_ready), 1);

    // Randomized traffic.
    do_reset();
    for (int r = 0; r < 30; r++) begin
      int nd;
      nd = int'($urandom_range(0, 5));
      for (int d = 0; d < nd; d++) begin
        deliver(int'($urandom_range(0, NP - 1)), int'($urandom_range(0, 15)) - 8,
                int'($urandom_range(0, 15)) - 8);
      end
      if ($urandom_range(0, 9) < 3) begin
        prog(int'($urandom_range(0, 1)), int'($urandom_range(0, NP - 1)),
             int'($urandom_range(0, 12)));
      end
      run_scan(0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, NP - 1)), int'($urandom_range(0, 15)) - 8,
               int'($urandom_range(0, 15)) - 8);
      check_state("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_jleugeri_ttt_accumulator.md
TT_UM_JLEUGERI_TTT_ACCUMULATOR -- requirements
Module: tt_um_jleugeri_ttt_accumulator

Interface
REQ-001 The module SHALL have parameter NUM_PROCESSORS, default 4, number of processors (≥2); ID width IW = $clog2(NUM_PROCESSORS).
REQ-002 The module SHALL have parameter NEW_TOKEN_BITS, default 4, width of the signed token deltas arriving from the network stage.
REQ-003 The module SHALL have parameter TOKEN_BITS, default 8, width of the per-processor token counters and thresholds.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  token delta present this cycle.
REQ-007 in_ready  out  1  delta accepted when in_valid && in_ready.
REQ-008 in_target_id  in  IW  processor receiving the delta.
REQ-009 in_new_good_tokens  in  NEW_TOKEN_BITS  signed good-token delta.
REQ-010 in_new_bad_tokens  in  NEW_TOKEN_BITS  signed bad-token delta.
REQ-011 scan_start  in  1  request a fire-evaluation pass over all processors.
REQ-012 prog_we  in  1  threshold write strobe.
REQ-013 prog_sel  in  1  0 = good threshold, 1 = bad threshold.
REQ-014 prog_processor_id  in  IW  processor whose threshold is written.
REQ-015 prog_value  in  TOKEN_BITS  unsigned threshold value.
REQ-016 fire_valid  out  1  fire_id holds a firing processor.
REQ-017 fire_ready  in  1  consumer accepts fire_id.
REQ-018 fire_id  out  IW  index of the firing processor.
REQ-019 scan_done  out  1  one-cycle pulse at the end of a scan pass.

Function
REQ-020 The state machine SHALL have the states IDLE and SCAN; reset enters IDLE.
REQ-021 in_ready SHALL be 1 in IDLE and 0 in SCAN; deltas offered during SCAN are not consumed and remain the upstream's responsibility.
REQ-022 On an accepted delta, good[t] and bad[t] (t = in_target_id) SHALL update next cycle to the sign-extended sum, clamped to [0, 2^TOKEN_BITS-1].
REQ-023 Back-to-back deltas to the same target on consecutive cycles SHALL accumulate with no loss, giving full throughput of one delta per cycle.
REQ-024 prog_we SHALL write good_thr or bad_thr of prog_processor_id in any state, effective from the next cycle.
REQ-025 scan_start in IDLE SHALL enter SCAN with index i = 0; scan_start in SCAN SHALL be ignored; if in_valid and scan_start coincide in IDLE, the delta SHALL be accumulated first and the scan started.
REQ-026 In SCAN, processor i fires iff good[i] >= good_thr[i] and bad[i] < bad_thr[i], evaluated on the current registered values.
REQ-027 A non-firing i SHALL advance i in one cycle with fire_valid = 0.
REQ-028 A firing i SHALL drive fire_valid = 1 and fire_id = i and hold both stable until fire_ready; on the handshake, good[i] and bad[i] SHALL clear to 0 and i SHALL advance.
REQ-029 After index NUM_PROCESSORS-1 is finished, scan_done SHALL pulse for exactly one cycle and the state SHALL return to IDLE; a full pass with no firing takes NUM_PROCESSORS cycles.
REQ-030 fire_valid SHALL never assert outside SCAN; fire_id SHALL be 0 when fire_valid = 0.

Reset
REQ-031 On reset, all good/bad counters SHALL be 0, every good_thr SHALL be 1, and every bad_thr SHALL be 1.
REQ-032 On reset, state SHALL be IDLE, i = 0, fire_valid = 0, fire_id = 0, scan_done = 0, and in_ready = 1 in the following cycle.
REQ-033 Reset asserted mid-SCAN SHALL abort the pass, with no scan_done and no counter clear beyond the reset values.

Verification
REQ-034 Deltas (t=2,+3,0), (t=2,+4,0), (t=2,-2,0) on consecutive cycles, then scan -> a single fire with fire_id = 2; good[2] = 5 before the clear, and good[2] = bad[2] = 0 after the handshake.
REQ-035 Set good_thr[1] = 6, deliver good +5, then scan -> no fire_valid and scan_done after 4 cycles; deliver +1 more and scan -> fire_id = 1.
REQ-036 Set bad_thr[0] = 2, deliver to t=0 good +3 and bad +2, then scan -> no fire; deliver bad -1 and scan -> fire_id = 0.
REQ-037 Saturation, TOKEN_BITS = 8: deliver 40 x (+7) to t=3 -> good[3] = 255; deliver (-8) to a counter at 3 -> counter = 0.
REQ-038 Processors 0 and 3 eligible, fire_ready held low 5 cycles -> fire_id = 0 held stable, no advance; then fires 0 and 3 in order, scan_done once, and in_ready = 0 throughout the scan.
REQ-039 Reset asserted while fire_valid = 1 -> next cycle fire_valid = 0, counters 0, thresholds 1, in_ready = 1, and no scan_done.
